modbus_slave_reg_bank: RTL and testbench

Parametrised per-slave register bank for the Modbus RTU multi-slave master. It sits after the frame parser and CRC checker. Register words addressed to SLAVE_ID are captured into a staging RAM, and only the words written in the current frame are committed to the output bus once the CRC validates. The block replaces the fixed 10-register, 16-bit per-slave demux, adding a dirty mask, sequential commit, frame discard on CRC error, per-register valid flags, an overrun flag and an optional link-stale watchdog.

---
 rtl/modbus_slave_reg_bank.sv | 158 +++++++++++++++
 tb/tb_modbus_slave_reg_bank.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/modbus_slave_reg_bank.sv
// modbus_slave_reg_bank
// Per-slave holding-register bank for the Modbus RTU master. Words addressed to SLAVE_ID are
// captured into a staging RAM and marked dirty. On a good CRC the dirty words are committed to
// data_out one index per cycle. A CRC error discards the pending frame.
//
// Optional build macro: DEMUX_STALE_EN adds a link-stale watchdog. Without it, link_stale is 0.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-high reset
//   adr          slave address of the current frame
//   n_data       1-based register index of data_in
//   data_in      register word from the parser
//   data_strb    word-valid strobe (rising edge sampled)
//   crc_validate frame CRC good (rising edge sampled)
//   crc_error    frame CRC bad, 1-cycle pulse
//   data_out     packed registers, register k at [k*DATA_W-1 -: DATA_W]
//   reg_valid    bit k-1 set once register k has been committed
//   upd_strb     1-cycle pulse after a commit completes
//   busy         high during the commit sweep
//   overrun      sticky: a matching capture was dropped during commit
//   link_stale   watchdog flag
module modbus_slave_reg_bank #(
  parameter logic [7:0]  SLAVE_ID     = 8'd2,
  parameter int unsigned NUM_REGS     = 10,
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned STALE_CYCLES = 50_000_000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [7:0]                   adr,
  input  logic [7:0]                   n_data,
  input  logic [DATA_W-1:0]            data_in,
  input  logic                         data_strb,
  input  logic                         crc_validate,
  input  logic                         crc_error,
  output logic [NUM_REGS*DATA_W-1:0]   data_out,
  output logic [NUM_REGS-1:0]          reg_valid,
  output logic                         upd_strb,
  output logic                         busy,
  output logic                         overrun,
  output logic                         link_stale
);

  typedef enum logic [1:0] {StIdle, StCommit, StDone} state_e;

  state_e                       state_q, state_d;
  logic [7:0]                   idx_q, idx_d;
  logic [NUM_REGS-1:0]          dirty_q, dirty_d;
  logic [NUM_REGS-1:0]          hit, commit_sel;
  logic                         overrun_q, overrun_d;
  logic                         strb_q, crc_q;
  logic                         strb_ev, crc_ev, adr_match, cap_en;
  logic [DATA_W-1:0]            staging_q [NUM_REGS];
  logic [NUM_REGS*DATA_W-1:0]   data_q;
  logic [NUM_REGS-1:0]          valid_q;

  assign strb_ev   = data_strb & ~strb_q;
  assign crc_ev    = crc_validate & ~crc_q;
  assign adr_match = (adr == SLAVE_ID);
  assign cap_en    = strb_ev && adr_match && (state_q == StIdle);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    overrun_d  = overrun_q;
    hit        = '0;
    commit_sel = '0;
    // Out-of-range indices match no slot and are therefore ignored.
    for (int k = 0; k < NUM_REGS; k++) begin
      hit[k]        = cap_en && (n_data == 8'(k + 1));
      commit_sel[k] = (state_q == StCommit) && (idx_q == 8'(k + 1)) && dirty_q[k];
    end
    dirty_d = (dirty_q | hit) & ~commit_sel;

    unique case (state_q)
      StIdle: begin
        // Error beats a coincident validate: the whole frame is discarded.
        if (crc_error) begin
          dirty_d = '0;
        end else if (crc_ev && (dirty_q != '0)) begin
          state_d = StCommit;
          idx_d   = 8'd1;
        end
      end
      StCommit: begin
        if (strb_ev && adr_match) overrun_d = 1'b1;
        if (idx_q == 8'(NUM_REGS)) begin
          state_d = StDone;
        end else begin
          idx_d = idx_q + 8'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      idx_q     <= 8'd0;
      dirty_q   <= '0;
      overrun_q <= 1'b0;
      strb_q    <= 1'b0;
      crc_q     <= 1'b0;
      data_q    <= '0;
      valid_q   <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      dirty_q   <= dirty_d;
      overrun_q <= overrun_d;
      strb_q    <= data_strb;
      crc_q     <= crc_validate;
      for (int k = 0; k < NUM_REGS; k++) begin
        if (commit_sel[k]) begin
          data_q[k*DATA_W +: DATA_W] <= staging_q[k];
          valid_q[k]                 <= 1'b1;
        end
      end
    end
  end

  // Staging contents only matter where dirty is set, so no reset is needed.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_REGS; k++) begin
      if (hit[k]) staging_q[k] <= data_in;
    end
  end

  assign data_out  = data_q;
  assign reg_valid = valid_q;
  assign busy      = (state_q == StCommit);
  assign upd_strb  = (state_q == StDone);
  assign overrun   = overrun_q;

`ifdef DEMUX_STALE_EN
  logic [31:0] stale_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stale_q <= 32'd0;
    end else if (upd_strb) begin
      stale_q <= 32'd0;
    end else if (stale_q != STALE_CYCLES) begin
      stale_q <= stale_q + 32'd1;
    end
  end

  assign link_stale = (stale_q == STALE_CYCLES);
`else
  logic unused_stale_cfg;
  assign unused_stale_cfg = ^STALE_CYCLES;
  assign link_stale       = 1'b0;
`endif

endmodule

// File: tb/tb_modbus_slave_reg_bank.sv
module tb_modbus_slave_reg_bank;
  localparam int unsigned NR = 10;
  localparam int unsigned DW = 16;
  localparam int unsigned W  = NR * DW;
`ifdef DEMUX_STALE_EN
  localparam logic STALE_ON = 1'b1;
`else
  localparam logic STALE_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    adr, n_data;
  logic [DW-1:0] data_in;
  logic          data_strb, crc_validate, crc_error;
  logic [W-1:0]  data_out;
  logic [NR-1:0] reg_valid;
  logic          upd_strb, busy, overrun, link_stale;

  modbus_slave_reg_bank #(
    .SLAVE_ID    (8'd2),
    .NUM_REGS    (NR),
    .DATA_W      (DW),
    .STALE_CYCLES(100)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .adr         (adr),
    .n_data      (n_data),
    .data_in     (data_in),
    .data_strb   (data_strb),
    .crc_validate(crc_validate),
    .crc_error   (crc_error),
    .data_out    (data_out),
    .reg_valid   (reg_valid),
    .upd_strb    (upd_strb),
    .busy        (busy),
    .overrun     (overrun),
    .link_stale  (link_stale)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model of the register bank.
  logic [DW-1:0] m_stage [1:NR];
  logic [DW-1:0] m_data  [1:NR];
  logic [NR:1]   m_dirty;
  logic [NR-1:0] m_valid;

  typedef struct {
    logic [W-1:0]  d;
    logic [NR-1:0] v;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] pack_model();
    logic [W-1:0] r;
    for (int k = 1; k <= NR; k++) r[(k-1)*DW +: DW] = m_data[k];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [7:0] a, input logic [7:0] n, input logic [DW-1:0] d);
    adr       = a;
    n_data    = n;
    data_in   = d;
    data_strb = 1'b1;
    tick();
    data_strb = 1'b0;
    tick();
    if (a == 8'd2 && int'(n) >= 1 && int'(n) <= NR) begin
      m_stage[int'(n)] = d;
      m_dirty[int'(n)] = 1'b1;
    end
  endtask

  task automatic crc_err_pulse();
    crc_error = 1'b1;
    tick();
    crc_error = 1'b0;
    tick();
    m_dirty = '0;
  endtask

  // Raise crc_validate (optionally with crc_error) and watch the next 20 cycles. With inject set,
  // a matching strobe is driven in the second commit cycle.
  task automatic validate(input string tag, input logic with_err, input logic inject);
    logic expect_commit;
    int   upd_at, upd_n, busy_n;
    exp_t e;
    expect_commit = (m_dirty != '0) && !with_err;
    if (with_err) m_dirty = '0;
    if (expect_commit) begin
      for (int k = 1; k <= NR; k++) begin
        if (m_dirty[k]) begin
          m_data[k]    = m_stage[k];
          m_valid[k-1] = 1'b1;
        end
      end
      m_dirty = '0;
      sb.push_back('{d: pack_model(), v: m_valid});
    end
    crc_validate = 1'b1;
    crc_error    = with_err;
    tick();
    crc_validate = 1'b0;
    crc_error    = 1'b0;
    upd_at = 0;
    upd_n  = 0;
    busy_n = 0;
    for (int i = 1; i <= 20; i++) begin
      if (inject && i == 2) begin
        adr       = 8'd2;
        n_data    = 8'd4;
        data_in   = 16'h4444;
        data_strb = 1'b1;
      end
      if (inject && i == 3) data_strb = 1'b0;
      if (upd_strb) begin
        upd_n++;
        if (upd_at == 0) upd_at = i;
      end
      if (busy) busy_n++;
      tick();
    end
    if (expect_commit) begin
      check({tag, "_upd_latency"}, W'(upd_at), W'(NR + 1));
      check({tag, "_upd_width"}, W'(upd_n), W'(1));
      check({tag, "_busy_cycles"}, W'(busy_n), W'(NR));
      e = sb.pop_front();
      check({tag, "_data_out"}, data_out, e.d);
      check({tag, "_reg_valid"}, W'(reg_valid), W'(e.v));
    end else begin
      check({tag, "_no_upd"}, W'(upd_n), W'(0));
      check({tag, "_no_busy"}, W'(busy_n), W'(0));
      check({tag, "_data_hold"}, data_out, pack_model());
      check({tag, "_valid_hold"}, W'(reg_valid), W'(m_valid));
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data_out"}, data_out, '0);
    check({tag, "_reg_valid"}, W'(reg_valid), '0);
    check({tag, "_upd_strb"}, W'(upd_strb), '0);
    check({tag, "_busy"}, W'(busy), '0);
    check({tag, "_overrun"}, W'(overrun), '0);
    check({tag, "_link_stale"}, W'(link_stale), '0);
  endtask

  initial begin
    reset        = 1'b1;
    adr          = 8'd0;
    n_data       = 8'd0;
    data_in      = '0;
    data_strb    = 1'b0;
    crc_validate = 1'b0;
    crc_error    = 1'b0;
    m_dirty      = '0;
    m_valid      = '0;
    for (int k = 1; k <= NR; k++) m_data[k] = '0;

    // Reset state.
    tick();
    tick();
    check_all_zero("reset");
    reset = 1'b0;

    // Watchdog: quiet before STALE_CYCLES, asserted after (only when built in).
    for (int i = 0; i < 50; i++) tick();
    check("stale_early", W'(link_stale), '0);
    for (int i = 0; i < 100; i++) tick();
    check("stale_late", W'(link_stale), W'(STALE_ON));

    // Two words, sparse commit.
    write_word(8'd2, 8'd1, 16'h1234);
    write_word(8'd2, 8'd10, 16'hBEEF);
    validate("t1", 1'b0, 1'b0);
    check("t1_valid_pattern", W'(reg_valid), W'(10'b10_0000_0001));
    check("t1_stale_cleared", W'(link_stale), '0);

    // Foreign address is ignored.
    write_word(8'd3, 8'd1, 16'hAAAA);
    validate("t2", 1'b0, 1'b0);

    // CRC error discards the frame; the next frame commits.
    write_word(8'd2, 8'd5, 16'h5555);
    crc_err_pulse();
    validate("t3a", 1'b0, 1'b0);
    write_word(8'd2, 8'd5, 16'h6666);
    validate("t3b", 1'b0, 1'b0);

    // Error coinciding with validate wins.
    write_word(8'd2, 8'd6, 16'h0606);
    validate("t3c", 1'b1, 1'b0);

    // Out-of-range indices.
    write_word(8'd2, 8'd0, 16'h0BAD);
    write_word(8'd2, 8'd11, 16'h0BAD);
    validate("t4", 1'b0, 1'b0);

    // Repeated index overwrites.
    write_word(8'd2, 8'd2, 16'h1111);
    write_word(8'd2, 8'd2, 16'h2222);
    validate("t_ovw", 1'b0, 1'b0);

    // Strobe during commit is dropped and flags overrun.
    write_word(8'd2, 8'd3, 16'h3333);
    validate("t5a", 1'b0, 1'b1);
    check("t5_overrun_set", W'(overrun), W'(1));
    validate("t5b", 1'b0, 1'b0);
    check("t5_overrun_sticky", W'(overrun), W'(1));

    // Reset asserted in the third commit cycle.
    write_word(8'd2, 8'd7, 16'h7777);
    crc_validate = 1'b1;
    tick();
    crc_validate = 1'b0;
    check("t5_busy_c1", W'(busy), W'(1));
    tick();
    tick();
    check("t5_busy_c3", W'(busy), W'(1));
    reset = 1'b1;
    #1;
    check_all_zero("t5_midreset");
    for (int k = 1; k <= NR; k++) m_data[k] = '0;
    m_valid = '0;
    m_dirty = '0;
    tick();
    reset = 1'b0;

    // Normal operation after reset.
    write_word(8'd2, 8'd4, 16'h00AA);
    validate("t_post", 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
